// File: rtl/ltc2308_pkg.sv
// Shared types and helpers for the LTC2308 scan controller: FSM states, config-word
// assembly and round-robin channel selection.
package ltc2308_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCnvHi,
        StCnvWait,
        StShift,
        StDone
    } state_e;

    localparam logic SD_SINGLE = 1'b1;
    localparam logic SLP_OFF   = 1'b0;
    localparam int unsigned NUM_BITS = 12;

    // Bit 5 is shifted first: {S/D, O/S, S1, S0, UNI, SLP}
    function automatic logic [5:0] cfg_word(input logic [2:0] ch, input logic uni);
        return {SD_SINGLE, ch[0], ch[2], ch[1], uni, SLP_OFF};
    endfunction

    // Lowest enabled channel at or above start, wrapping past CH7
    function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] start);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ltc2308_shifter.sv
// Serial engine for one LTC2308 frame: generates 12 SCK periods, shifts the config
// word out on SDI and captures SDO MSB first.
module ltc2308_shifter
    import ltc2308_pkg::*;
#(
    parameter int unsigned SCK_DIV = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cfg,
    input  logic        sdo,
    output logic        sck,
    output logic        sdi,
    output logic        done,
    output logic [11:0] data
);

    localparam int unsigned DivW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DivW-1:0] DIV_LAST = DivW'(SCK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(NUM_BITS - 1);

    logic            active;
    logic            high;
    logic [DivW-1:0] div_cnt;
    logic [3:0]      bit_idx;
    logic [5:0]      cfg_reg;

    // Asserted during the final high cycle of bit 11
    assign done = active && high && (div_cnt == DIV_LAST) && (bit_idx == BIT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            active  <= 1'b0;
            high    <= 1'b0;
            div_cnt <= '0;
            bit_idx <= '0;
            cfg_reg <= '0;
            sck     <= 1'b0;
            sdi     <= 1'b0;
            data    <= '0;
        end else if (start) begin
            active  <= 1'b1;
            high    <= 1'b0;
            div_cnt <= '0;
            bit_idx <= '0;
            sck     <= 1'b0;
            sdi     <= cfg[5];
            cfg_reg <= {cfg[4:0], 1'b0};
        end else if (active) begin
            if (div_cnt != DIV_LAST) begin
                div_cnt <= div_cnt + DivW'(1);
            end else begin
                div_cnt <= '0;
                if (!high) begin
                    high <= 1'b1;
                    sck  <= 1'b1;
                end else begin
                    high <= 1'b0;
                    sck  <= 1'b0;
                    data <= {data[10:0], sdo};
                    if (bit_idx == BIT_LAST) begin
                        active <= 1'b0;
                        sdi    <= 1'b0;
                    end else begin
                        // Zero fill drives SDI low for bits 6..11
                        bit_idx <= bit_idx + 4'd1;
                        sdi     <= cfg_reg[5];
                        cfg_reg <= {cfg_reg[4:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ltc2308_scan_ctrl.sv
// Free-running LTC2308 scan controller: round-robins enabled channels, tracks the
// one-frame config pipeline and holds tagged results in a valid/ready register.
module ltc2308_scan_ctrl
    import ltc2308_pkg::*;
#(
    parameter int unsigned SCK_DIV       = 2,
    parameter int unsigned CONVST_CYCLES = 2,
    parameter int unsigned CONV_CYCLES   = 80,
    parameter int unsigned NUM_CH        = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              uni,
    output logic              adc_convst,
    output logic              adc_sck,
    output logic              adc_sdi,
    input  logic              adc_sdo,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [11:0]       result_data,
    output logic [2:0]        result_ch,
    output logic [7:0]        overrun_cnt,
    output logic              busy
);

    localparam int unsigned CntMax = (CONV_CYCLES > CONVST_CYCLES) ? CONV_CYCLES : CONVST_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    state_e        state;
    logic [CntW-1:0] cnt;
    logic [2:0]    cfg_ch;
    logic [2:0]    conv_ch;
    logic [2:0]    next_ch;
    logic          dummy;
    logic          scan_req;
    logic          shift_start;
    logic          shift_done;
    logic [11:0]   shift_data;
    logic [5:0]    cfg;

    assign scan_req    = enable && (ch_mask != '0);
    assign shift_start = (state == StCnvWait) && (cnt == CntW'(CONV_CYCLES - 1));
    assign cfg         = cfg_word(cfg_ch, uni);

    ltc2308_shifter #(
        .SCK_DIV (SCK_DIV)
    ) u_shifter (
        .clock (clock),
        .reset (reset),
        .start (shift_start),
        .cfg   (cfg),
        .sdo   (adc_sdo),
        .sck   (adc_sck),
        .sdi   (adc_sdi),
        .done  (shift_done),
        .data  (shift_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StIdle;
            cnt          <= '0;
            cfg_ch       <= '0;
            conv_ch      <= '0;
            next_ch      <= '0;
            dummy        <= 1'b1;
            adc_convst   <= 1'b0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_ch    <= '0;
            overrun_cnt  <= '0;
            busy         <= 1'b0;
        end else begin
            if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (scan_req) begin
                        cfg_ch     <= rr_pick(ch_mask, next_ch);
                        cnt        <= '0;
                        adc_convst <= 1'b1;
                        busy       <= 1'b1;
                        state      <= StCnvHi;
                    end
                end
                StCnvHi: begin
                    if (cnt == CntW'(CONVST_CYCLES - 1)) begin
                        cnt        <= '0;
                        adc_convst <= 1'b0;
                        state      <= StCnvWait;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StCnvWait: begin
                    if (shift_start) begin
                        state <= StShift;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StShift: begin
                    if (shift_done) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (!dummy) begin
                        // A same-cycle handshake frees the slot, so only a held result overruns
                        result_valid <= 1'b1;
                        result_data  <= shift_data;
                        result_ch    <= conv_ch;
                        if (result_valid && !result_ready && overrun_cnt != 8'hFF) begin
                            overrun_cnt <= overrun_cnt + 8'd1;
                        end
                    end
                    conv_ch <= cfg_ch;
                    next_ch <= cfg_ch + 3'd1;
                    if (scan_req) begin
                        dummy      <= 1'b0;
                        cfg_ch     <= rr_pick(ch_mask, cfg_ch + 3'd1);
                        cnt        <= '0;
                        adc_convst <= 1'b1;
                        state      <= StCnvHi;
                    end else begin
                        dummy <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ltc2308_scan_ctrl.sv
// Directed bench for ltc2308_scan_ctrl with a behavioural LTC2308 that returns a fixed
// code per channel, converting the channel configured in the previous frame.
module tb_ltc2308_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  ch_mask;
    logic        uni;
    logic        adc_convst;
    logic        adc_sck;
    logic        adc_sdi;
    logic        adc_sdo = 1'b0;
    logic        result_valid;
    logic        result_ready;
    logic [11:0] result_data;
    logic [2:0]  result_ch;
    logic [7:0]  overrun_cnt;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    ltc2308_scan_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .uni          (uni),
        .adc_convst   (adc_convst),
        .adc_sck      (adc_sck),
        .adc_sdi      (adc_sdi),
        .adc_sdo      (adc_sdo),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .result_ch    (result_ch),
        .overrun_cnt  (overrun_cnt),
        .busy         (busy)
    );

    // ADC model state
    logic [11:0] code_tbl [8] = '{12'hABC, 12'h111, 12'h5A3, 12'h333,
                                  12'h444, 12'hC3E, 12'h666, 12'h9F1};
    logic [11:0] cur_code;
    logic [5:0]  cfg_cap   = '0;
    logic [5:0]  last_cfg  = '0;
    logic [2:0]  adc_ch    = '0;
    logic        convst_prev = 1'b0;
    logic        sck_prev    = 1'b0;
    int          bit_idx   = 0;
    int          sck_rises = 0;
    int          rise_cnt  = 0;
    int          rise_cyc  = 0;
    int          period    = 0;
    int          cyc       = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (adc_convst && !convst_prev) begin
            last_cfg  = cfg_cap;
            period    = cyc - rise_cyc;
            rise_cyc  = cyc;
            rise_cnt  = rise_cnt + 1;
            adc_ch    = {cfg_cap[3], cfg_cap[2], cfg_cap[4]};
            bit_idx   = 0;
            sck_rises = 0;
            cfg_cap   = '0;
        end
        if (adc_sck && !sck_prev) begin
            if (sck_rises < 6) cfg_cap = {cfg_cap[4:0], adc_sdi};
            sck_rises = sck_rises + 1;
        end
        if (!adc_sck && sck_prev) bit_idx = bit_idx + 1;
        convst_prev = adc_convst;
        sck_prev    = adc_sck;
        cur_code    = code_tbl[adc_ch];
        adc_sdo     = (bit_idx < 12) ? cur_code[11 - bit_idx] : 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_rise();
        int start;
        bit seen;
        start = rise_cnt;
        seen  = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            #1;
            if (rise_cnt != start) seen = 1'b1;
        end
        chk("convst_rise_seen", int'(seen), 1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_convst"}, int'(adc_convst), 0);
        chk({tag, "_sck"}, int'(adc_sck), 0);
        chk({tag, "_sdi"}, int'(adc_sdi), 0);
        chk({tag, "_valid"}, int'(result_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_data"}, int'(result_data), 0);
        chk({tag, "_ch"}, int'(result_ch), 0);
        chk({tag, "_ovr"}, int'(overrun_cnt), 0);
    endtask

    typedef struct {
        logic [7:0]  mask;
        logic        uni;
        logic        ready;
        logic [5:0]  cfg;
        logic        valid;
        logic [2:0]  ch;
        logic [11:0] data;
        logic [7:0]  ovr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Inputs applied just after a frame starts; expectations at the next frame start
        vecs[0] = '{8'h25, 1'b1, 1'b1, 6'b100010, 1'b0, 3'd0, 12'h000, 8'd0};
        vecs[1] = '{8'h25, 1'b1, 1'b1, 6'b100110, 1'b1, 3'd0, 12'hABC, 8'd0};
        vecs[2] = '{8'h25, 1'b1, 1'b1, 6'b111010, 1'b1, 3'd2, 12'h5A3, 8'd0};
        vecs[3] = '{8'h25, 1'b1, 1'b1, 6'b100010, 1'b1, 3'd5, 12'hC3E, 8'd0};
        vecs[4] = '{8'h01, 1'b0, 1'b1, 6'b100100, 1'b1, 3'd0, 12'hABC, 8'd0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 6'b100010, 1'b1, 3'd2, 12'h5A3, 8'd0};
        vecs[6] = '{8'h01, 1'b1, 1'b0, 6'b100010, 1'b1, 3'd0, 12'hABC, 8'd1};
        vecs[7] = '{8'h01, 1'b1, 1'b0, 6'b100010, 1'b1, 3'd0, 12'hABC, 8'd2};

        reset        = 1'b1;
        enable       = 1'b0;
        ch_mask      = 8'h00;
        uni          = 1'b0;
        result_ready = 1'b1;
        tick(3);
        chk_all_zero("reset");
        reset = 1'b0;
        tick(5);
        chk("idle_no_enable_busy", int'(busy), 0);

        enable  = 1'b1;
        ch_mask = 8'h25;
        uni     = 1'b1;
        wait_rise();

        for (int i = 0; i < 8; i++) begin
            ch_mask      = vecs[i].mask;
            uni          = vecs[i].uni;
            result_ready = vecs[i].ready;
            wait_rise();
            chk($sformatf("v%0d_cfg", i), int'(last_cfg), int'(vecs[i].cfg));
            chk($sformatf("v%0d_valid", i), int'(result_valid), int'(vecs[i].valid));
            chk($sformatf("v%0d_ch", i), int'(result_ch), int'(vecs[i].ch));
            chk($sformatf("v%0d_data", i), int'(result_data), int'(vecs[i].data));
            chk($sformatf("v%0d_ovr", i), int'(overrun_cnt), int'(vecs[i].ovr));
            chk($sformatf("v%0d_period", i), period, 131);
        end

        // Handshake in the DONE cycle: consume-then-load, no overrun
        tick(130);
        chk("done_cycle_busy", int'(busy), 1);
        result_ready = 1'b1;
        wait_rise();
        chk("same_cycle_valid", int'(result_valid), 1);
        chk("same_cycle_ovr", int'(overrun_cnt), 2);
        chk("same_cycle_data", int'(result_data), 12'hABC);
        tick(1);
        chk("same_cycle_consumed", int'(result_valid), 0);

        // Mask change during SHIFT only affects the next selection
        tick(100);
        ch_mask = 8'h80;
        wait_rise();
        chk("mask_chg_cur_cfg", int'(last_cfg), 6'b100010);
        wait_rise();
        chk("mask_chg_next_cfg", int'(last_cfg), 6'b111110);
        chk("mask_chg_result_ch", int'(result_ch), 0);

        // Disable mid-SHIFT: frame completes, then idles
        tick(100);
        enable = 1'b0;
        for (int i = 0; i < 200 && busy; i++) tick(1);
        chk("disable_busy", int'(busy), 0);
        chk("disable_sck_rises", sck_rises, 12);
        chk("disable_cfg", int'(cfg_cap), 6'b111110);
        chk("disable_valid", int'(result_valid), 1);
        chk("disable_ch", int'(result_ch), 7);
        chk("disable_data", int'(result_data), 12'h9F1);
        tick(5);
        chk("disable_stays_idle", int'(busy | adc_convst), 0);
        enable = 1'b1;
        wait_rise();
        wait_rise();
        chk("reenable_dummy_valid", int'(result_valid), 0);
        chk("reenable_cfg", int'(last_cfg), 6'b111110);

        // Reset during CNV_WAIT
        tick(20);
        reset = 1'b1;
        tick(1);
        chk_all_zero("rst_wait");
        reset = 1'b0;

        // Reset during SHIFT bit 5
        wait_rise();
        tick(103);
        chk("bit5_busy", int'(busy), 1);
        reset = 1'b1;
        tick(1);
        chk_all_zero("rst_shift");
        reset = 1'b0;
        wait_rise();
        wait_rise();
        chk("post_rst_dummy_valid", int'(result_valid), 0);
        wait_rise();
        chk("post_rst_valid", int'(result_valid), 1);
        chk("post_rst_ch", int'(result_ch), 7);
        chk("post_rst_data", int'(result_data), 12'h9F1);
        chk("post_rst_period", period, 131);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
